// File: rtl/adc_uart_pkg.sv
// Shared definitions for the ADC-to-UART framer: FSM states, frame layout and byte builder.
package adc_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         FRAME_LEN     = 4;
  localparam int         IDX_W         = $clog2(FRAME_LEN);

  // Frame layout: SYNC, SEQ, {ovf, sample[14:8]}, sample[7:0]; sample arrives zero-extended.
  function automatic logic [7:0] frame_byte(
    input logic [7:0]       sync,
    input logic [IDX_W-1:0] idx,
    input logic [7:0]       seq,
    input logic             ovf,
    input logic [14:0]      smp
  );
    logic [7:0] b;
    case (idx)
      2'd0:    b = sync;
      2'd1:    b = seq;
      2'd2:    b = {ovf, smp[14:8]};
      default: b = smp[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/adc_uart_sfifo.sv
// Synchronous sample FIFO with show-ahead read; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module adc_uart_sfifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_uart_framer.sv
// Buffers ADC samples and frames each as SYNC/SEQ/HI/LO bytes for a UART transmitter
// using a start/busy byte handshake.
module adc_uart_framer
  import adc_uart_pkg::*;
#(
  parameter int         DATA_W     = 12,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter int         BUSY_TO    = 7
) (
  input  logic              adc_uart_framer_clk,
  input  logic              adc_uart_framer_rst_n,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic              frame_active
);

  localparam int               TO_W     = $clog2(BUSY_TO);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TO - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        seq_q;
  logic [TO_W-1:0]   to_q;
  logic [DATA_W-1:0] smp_q;
  logic              ovf_q, ovf_d;
  logic              ovf_lat_q;
  logic              tx_start_q;
  logic [7:0]        tx_data_q;
  logic              frame_active_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              pop;
  logic              ovf_set;

  // Pop is combinational so the sample leaves the FIFO in the same cycle IDLE decides to start.
  assign pop     = (state_q == S_IDLE) && !fifo_empty && !tx_busy;
  assign ovf_set = smp_valid && fifo_full && !pop;
  assign ovf_d   = ovf_set || (ovf_q && !ovf_clr);

  adc_uart_sfifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (adc_uart_framer_clk),
    .rst_n   (adc_uart_framer_rst_n),
    .push_i  (smp_valid),
    .wdata_i (smp_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge adc_uart_framer_clk or negedge adc_uart_framer_rst_n) begin
    if (!adc_uart_framer_rst_n) ovf_q <= 1'b0;
    else                        ovf_q <= ovf_d;
  end

  always_ff @(posedge adc_uart_framer_clk or negedge adc_uart_framer_rst_n) begin
    if (!adc_uart_framer_rst_n) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      seq_q          <= '0;
      to_q           <= '0;
      smp_q          <= '0;
      ovf_lat_q      <= 1'b0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      frame_active_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            smp_q          <= fifo_rdata;
            idx_q          <= '0;
            frame_active_q <= 1'b1;
            state_q        <= S_LOAD;
          end
        end
        S_LOAD: begin
          ovf_lat_q  <= ovf_q;
          tx_data_q  <= frame_byte(SYNC_BYTE, '0, seq_q, ovf_q, 15'(smp_q));
          tx_start_q <= 1'b1;
          state_q    <= S_START;
        end
        S_START: begin
          to_q    <= '0;
          state_q <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          // A missing busy rise is treated as a sent byte so the frame can never stall.
          if (tx_busy || to_q == TO_LAST) state_q <= S_WAIT_LO;
          else                            to_q    <= to_q + 1'b1;
        end
        S_WAIT_LO: begin
          if (!tx_busy) begin
            if (idx_q == IDX_LAST) begin
              seq_q          <= seq_q + 8'd1;
              frame_active_q <= 1'b0;
              state_q        <= S_IDLE;
            end else begin
              idx_q      <= idx_q + 1'b1;
              tx_data_q  <= frame_byte(SYNC_BYTE, idx_q + 1'b1, seq_q, ovf_lat_q, 15'(smp_q));
              tx_start_q <= 1'b1;
              state_q    <= S_START;
            end
          end
        end
        default: begin
          frame_active_q <= 1'b0;
          state_q        <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign ovf          = ovf_q;
  assign frame_active = frame_active_q;

endmodule

// File: tb/tb_adc_uart_framer.sv
// Self-checking bench for adc_uart_framer: a busy-line model plays the UART transmitter and
// expected frames come from an arithmetic model of the frame format.
module tb_adc_uart_framer;

  localparam int         DATA_W     = 12;
  localparam int         FIFO_DEPTH = 4;
  localparam int         BUSY_TO    = 7;
  localparam logic [7:0] SYNC       = 8'hA5;

  typedef enum {B_NORMAL, B_HI, B_LO, B_RAND} busy_mode_e;

  logic              clk;
  logic              rst_n;
  logic              smp_valid;
  logic [DATA_W-1:0] smp_data;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              ovf;
  logic              ovf_clr;
  logic              frame_active;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         exp_seq = 0;
  int         total_bytes = 0;
  logic [7:0] got_bytes [$];
  int         start_cyc [$];
  int         last_st [4];
  busy_mode_e busy_mode = B_NORMAL;
  int         rise_in = 0;
  int         busy_left = 0;

  adc_uart_framer #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .SYNC_BYTE  (SYNC),
    .BUSY_TO    (BUSY_TO)
  ) dut (
    .adc_uart_framer_clk   (clk),
    .adc_uart_framer_rst_n (rst_n),
    .smp_valid             (smp_valid),
    .smp_data              (smp_data),
    .tx_busy               (tx_busy),
    .tx_start              (tx_start),
    .tx_data               (tx_data),
    .ovf                   (ovf),
    .ovf_clr               (ovf_clr),
    .frame_active          (frame_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Records every byte handed to the transmitter with the cycle of its start pulse.
  initial forever begin
    @(negedge clk);
    if (tx_start === 1'b1) begin
      got_bytes.push_back(tx_data);
      start_cyc.push_back(cyc);
      total_bytes++;
    end
  end

  // Transmitter model: busy rises some cycles after a start pulse and stays high for a while.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rise_in > 0) begin
        rise_in--;
        if (rise_in == 0) busy_left = (busy_mode == B_RAND) ? int'($urandom_range(1, 6)) : 10;
      end
      if (tx_start === 1'b1) rise_in = (busy_mode == B_RAND) ? int'($urandom_range(1, 3)) : 1;
      case (busy_mode)
        B_HI: begin tx_busy = 1'b1; busy_left = 0; rise_in = 0; end
        B_LO: begin tx_busy = 1'b0; busy_left = 0; rise_in = 0; end
        default: begin
          tx_busy = (busy_left > 0);
          if (busy_left > 0) busy_left--;
        end
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_frame(input int smp, input int seq, input bit ovf_bit);
    logic [7:0] b1, b2, b3;
    b1 = 8'(seq % 256);
    b2 = 8'((ovf_bit ? 128 : 0) + (smp / 256) % 128);
    b3 = 8'(smp % 256);
    return {SYNC, b1, b2, b3};
  endfunction

  task automatic set_busy_mode(input busy_mode_e m);
    @(posedge clk);
    #1 busy_mode = m;
  endtask

  task automatic push(input logic [DATA_W-1:0] v);
    @(negedge clk);
    smp_valid = 1'b1;
    smp_data  = v;
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  task automatic get_frame(input int bound, output logic [31:0] frm, output bit ok);
    int n = 0;
    logic [7:0] b;
    frm = '0;
    ok  = 1'b0;
    while (got_bytes.size() < 4 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (got_bytes.size() >= 4) begin
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
        b = got_bytes.pop_front();
        frm = {frm[23:0], b};
        last_st[i] = start_cyc.pop_front();
      end
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    int n = 0;
    while (frame_active !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    ok = (frame_active === 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_bytes.delete();
    start_cyc.delete();
    exp_seq = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; smp_valid = 1'b0; smp_data = '0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_start !== 1'b0)     begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00)     begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (ovf !== 1'b0)          begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL reset_frame_active: got %b want 0", frame_active); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (frame_active !== 1'b0 || got_bytes.size() != 0) begin
      errors++; $display("FAIL idle_after_reset: frame_active %b bytes %0d want 0 0", frame_active, got_bytes.size());
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] frm;
    bit ok;
    int p;
    set_busy_mode(B_NORMAL);
    @(negedge clk);
    smp_valid = 1'b1; smp_data = 12'hABC; p = cyc;
    @(negedge clk);
    smp_valid = 1'b0;
    get_frame(200, frm, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_frame: timeout, want 4 bytes"); return; end
    if (frm !== 32'hA5000ABC) begin errors++; $display("FAIL single_frame: got %h want A5000ABC", frm); end
    exp_seq = (exp_seq + 1) % 256;
    checks++;
    if (last_st[0] != p + 3) begin errors++; $display("FAIL first_start_latency: got cycle %0d want %0d", last_st[0], p + 3); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (last_st[i+1] - last_st[i] != 12) begin
        errors++; $display("FAIL byte_gap%0d: got %0d want 12", i, last_st[i+1] - last_st[i]);
      end
    end
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_frame_active_fall: got %b want 0", frame_active); end
    repeat (30) @(negedge clk);
    checks++;
    if (got_bytes.size() != 0) begin errors++; $display("FAIL single_pulse_count: got %0d extra bytes want 0", got_bytes.size()); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp_smp [$];
    logic [DATA_W-1:0] v;
    logic [31:0]       frm;
    logic [7:0]        b;
    int pushed = 0, frames = 0, n = 0, base, started;
    bit ok;
    do_reset();
    set_busy_mode(B_RAND);
    base = total_bytes;
    while (frames < 257 && n < 30000) begin
      @(negedge clk);
      n++;
      smp_valid = 1'b0;
      started = (total_bytes - base + 3) / 4;
      if (pushed < 257 && pushed - started < FIFO_DEPTH && $urandom_range(0, 1) == 1) begin
        v = DATA_W'($urandom);
        smp_data = v; smp_valid = 1'b1;
        exp_smp.push_back(v);
        pushed++;
      end
      if (got_bytes.size() >= 4) begin
        frm = '0;
        for (int i = 0; i < 4; i++) begin
          b = got_bytes.pop_front();
          frm = {frm[23:0], b};
          void'(start_cyc.pop_front());
        end
        checks++;
        if (frm !== model_frame(int'(exp_smp[0]), exp_seq, 1'b0)) begin
          errors++; $display("FAIL b2b_frame%0d: got %h want %h", frames, frm, model_frame(int'(exp_smp[0]), exp_seq, 1'b0));
        end
        void'(exp_smp.pop_front());
        exp_seq = (exp_seq + 1) % 256;
        frames++;
      end
    end
    smp_valid = 1'b0;
    checks++; if (frames != 257) begin errors++; $display("FAIL b2b_count: got %0d frames want 257", frames); end
    wait_idle(100, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (got_bytes.size() != 0 || ovf !== 1'b0) begin
      errors++; $display("FAIL b2b_tail: extra bytes %0d ovf %b want 0 0", got_bytes.size(), ovf);
    end
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] s [6];
    logic [31:0] frm;
    bit ok;
    do_reset();
    set_busy_mode(B_HI);
    for (int i = 0; i < 6; i++) s[i] = DATA_W'($urandom);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      smp_valid = 1'b1; smp_data = s[i];
    end
    @(negedge clk);
    smp_valid = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL ovf_busy_hold: frame_active %b want 0", frame_active); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    ovf_clr = 1'b1; smp_valid = 1'b1; smp_data = DATA_W'($urandom);
    @(negedge clk);
    ovf_clr = 1'b0; smp_valid = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b want 1", ovf); end
    set_busy_mode(B_NORMAL);
    for (int i = 0; i < 4; i++) begin
      get_frame(300, frm, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ovf_frame%0d: timeout", i); return; end
      if (frm !== model_frame(int'(s[i]), exp_seq, i == 0)) begin
        errors++; $display("FAIL ovf_frame%0d: got %h want %h", i, frm, model_frame(int'(s[i]), exp_seq, i == 0));
      end
      exp_seq = (exp_seq + 1) % 256;
      if (i == 0) begin
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
      end
    end
    wait_idle(100, ok);
    repeat (30) @(negedge clk);
    checks++;
    if (got_bytes.size() != 0) begin errors++; $display("FAIL ovf_dropped: got %0d extra bytes want 0", got_bytes.size()); end
  endtask

  task automatic test_full_push_pop();
    logic [DATA_W-1:0] s [5];
    logic [31:0] frm;
    bit ok;
    do_reset();
    set_busy_mode(B_HI);
    for (int i = 0; i < 5; i++) s[i] = DATA_W'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      smp_valid = 1'b1; smp_data = s[i];
    end
    @(negedge clk);
    smp_valid = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL full_no_ovf: got %b want 0", ovf); end
    set_busy_mode(B_NORMAL);
    @(negedge clk);
    smp_valid = 1'b1; smp_data = s[4];
    @(negedge clk);
    smp_valid = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL push_pop_ovf: got %b want 0", ovf); end
    for (int i = 0; i < 5; i++) begin
      get_frame(300, frm, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL push_pop_frame%0d: timeout", i); return; end
      if (frm !== model_frame(int'(s[i]), exp_seq, 1'b0)) begin
        errors++; $display("FAIL push_pop_frame%0d: got %h want %h", i, frm, model_frame(int'(s[i]), exp_seq, 1'b0));
      end
      exp_seq = (exp_seq + 1) % 256;
    end
  endtask

  task automatic test_timeout();
    logic [DATA_W-1:0] v;
    logic [31:0] frm;
    bit ok;
    int g;
    set_busy_mode(B_LO);
    v = DATA_W'($urandom);
    push(v);
    get_frame(300, frm, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_frame: timeout, FSM stalled"); return; end
    if (frm !== model_frame(int'(v), exp_seq, 1'b0)) begin
      errors++; $display("FAIL timeout_frame: got %h want %h", frm, model_frame(int'(v), exp_seq, 1'b0));
    end
    exp_seq = (exp_seq + 1) % 256;
    for (int i = 0; i < 3; i++) begin
      g = last_st[i+1] - last_st[i];
      checks++;
      if (g < BUSY_TO + 1 || g > BUSY_TO + 2) begin
        errors++; $display("FAIL timeout_gap%0d: got %0d want %0d..%0d", i, g, BUSY_TO + 1, BUSY_TO + 2);
      end
    end
    wait_idle(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_idle: frame_active %b want 0", frame_active); end
  endtask

  task automatic test_reset_mid_frame();
    logic [DATA_W-1:0] va, vb;
    logic [31:0] frm, exp;
    bit ok;
    int n = 0;
    set_busy_mode(B_NORMAL);
    va = DATA_W'($urandom);
    push(va);
    while (got_bytes.size() < 3 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (got_bytes.size() < 3) begin errors++; $display("FAIL midreset_partial: got %0d bytes want 3", got_bytes.size()); return; end
    exp = model_frame(int'(va), exp_seq, 1'b0);
    if ({got_bytes[0], got_bytes[1], got_bytes[2]} !== exp[31:8]) begin
      errors++; $display("FAIL midreset_partial: got %h want %h", {got_bytes[0], got_bytes[1], got_bytes[2]}, exp[31:8]);
    end
    repeat (2) @(negedge clk);
    checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL midreset_active: got %b want 1", frame_active); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || ovf !== 1'b0 || frame_active !== 1'b0) begin
      errors++; $display("FAIL async_reset: start %b data %h ovf %b active %b want 0 00 0 0", tx_start, tx_data, ovf, frame_active);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    got_bytes.delete();
    start_cyc.delete();
    exp_seq = 0;
    vb = DATA_W'($urandom);
    push(vb);
    get_frame(300, frm, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL post_reset_frame: timeout"); return; end
    if (frm !== model_frame(int'(vb), 0, 1'b0)) begin
      errors++; $display("FAIL post_reset_frame: got %h want %h", frm, model_frame(int'(vb), 0, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_timeout();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
